mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single shared memory port between the instruction-fetch requester and the load/store requester. It also sequences each access through its fixed read latency, replacing the hard-coded delay states in the main control FSM. It sits between the multicycle control unit and the memory. It registers address, write data and write enable, counts wait cycles, captures read data and returns a one-cycle done pulse to the winning requester.

## Interface
- MEM_LATENCY, 2: read wait cycles between address presentation and valid MemRdata; legal range 1..15
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- FetchReq  in  1  fetch requester wants a read; held until FetchDone
- FetchAddr  in  32  fetch address (PC)
- DataReq  in  1  load/store requester wants an access; held until DataDone
- DataWr  in  1  1 = store, 0 = load
- DataAddr  in  32  load/store address
- DataWdata  in  32  store data
- MemRdata  in  32  memory read data
- MemAddr  out  32  registered memory address
- MemWr  out  1  registered memory write strobe
- MemWdata  out  32  registered memory write data
- RdData  out  32  captured read data, held until next read completes
- FetchDone  out  1  one-cycle completion pulse to fetch
- DataDone  out  1  one-cycle completion pulse to load/store
- Grant  out  1  owner of current/last access: 0 fetch, 1 data
- Busy  out  1  state != IDLE
- StateOut  out  2  current state encoding, debug

## Operation
- States:
  - IDLE=0: arbitrate when any request is present.
  - RWAIT=1: read in flight.
  - WRITE=2: single write cycle.
  - DONE=3: completion pulse.
- IDLE, any Req sampled high:
  - Pick the winner and latch its address into MemAddr. Latch DataWdata into MemWdata if the winner is data. Set Grant.
  - Winner is a store: go to WRITE.
  - Otherwise load counter with MEM_LATENCY and go to RWAIT.
- IDLE, no request: stay in IDLE; MemWr=0.
- RWAIT:
  - Counter decrements each cycle; MemAddr held.
  - When the counter reaches 1: RdData <= MemRdata, go to DONE.
- WRITE: MemWr=1 for exactly this cycle, then go to DONE. MemWr is 0 in every other state.
- DONE:
  - FetchDone or DataDone = 1 according to Grant.
  - Always return to IDLE; no arbitration in DONE.
  - The requester must drop Req on the edge ending DONE.
- Default arbitration: fixed priority, data over fetch.
- Req dropped mid-access: the access completes and the Done pulse is still issued. Requests are sampled only in IDLE.
- Addresses pass through unmodified; no alignment checks.
- Illegal state encoding: next state is IDLE.

## Timing
- Reset values: MemAddr, MemWdata and RdData are 0; MemWr, FetchDone, DataDone, Grant and Busy are 0; StateOut=IDLE; counter 0.
- Request sampled at the end of cycle 0. MemAddr is valid from cycle 1.
- Read:
  - RWAIT occupies cycles 1..L (L = MEM_LATENCY).
  - MemRdata is sampled at the end of cycle L.
  - Done and valid RdData in cycle L+1. IDLE in cycle L+2.
  - Occupancy is L+2 cycles per read.
- Write: MemWr=1 in cycle 1, Done in cycle 2, IDLE in cycle 3.
- A request held continuously gets its next grant in the IDLE cycle after DONE.
- Reset asserted in any cycle: all outputs take their reset values from the next cycle. No pending Done pulse is emitted; the in-flight access is abandoned.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration.
  - When both requests are high in IDLE, grant the requester not served last (Grant from the previous access). After reset the last-served requester is fetch, so data wins the first tie.
  - A single request is always granted.
- Not defined: fixed data-over-fetch priority; the last-served register is not built.

## Test plan
- Fetch read, L=2: FetchReq=1, FetchAddr=0x00000004 in cycle 0; MemRdata=0x8C220000 in cycle 2 -> MemAddr=0x4 in cycles 1–2, FetchDone=1 and RdData=0x8C220000 in cycle 3, MemWr=0 throughout, Busy=0 in cycle 4.
- Store: DataReq=1, DataWr=1, DataAddr=0x100, DataWdata=0xDEADBEEF in cycle 0 -> MemWr=1 only in cycle 1 with MemAddr=0x100 and MemWdata=0xDEADBEEF, DataDone=1 in cycle 2, RdData unchanged.
- Tie, fixed priority, both reads, L=2: FetchReq=DataReq=1 (DataAddr=0x200, FetchAddr=0x8) in cycle 0 -> Grant=1 with DataDone in cycle 3; fetch granted in cycle 4, MemAddr=0x8 in cycles 5–6, FetchDone in cycle 7.
- Tie with MEM_ARB_RR_EN, Grant=1 from the previous access: both requests in IDLE -> fetch served first (Grant=0); data served on the next arbitration.
- Reset mid-read: Reset=1 in cycle 1 of a fetch -> cycle 2 has all outputs 0 and StateOut=0, and no FetchDone is ever pulsed for that access.
- Request withdrawn: DataReq drops in cycle 1 of a load -> DataDone still pulses in cycle 3; IDLE in cycle 4 with no new grant.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/load-store requesters, the memory and mem_port_arbiter.
// master: requesters plus memory read data; slave: the arbiter itself.
interface mem_port_arbiter_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] rd_data;
    logic        fetch_done;
    logic        data_done;
    logic        grant;
    logic        busy;
    logic [1:0]  state_out;

    modport master (
        output fetch_req, fetch_addr, data_req, data_wr, data_addr, data_wdata, mem_rdata,
        input  mem_addr, mem_wr, mem_wdata, rd_data, fetch_done, data_done, grant, busy, state_out
    );

    modport slave (
        input  fetch_req, fetch_addr, data_req, data_wr, data_addr, data_wdata, mem_rdata,
        output mem_addr, mem_wr, mem_wdata, rd_data, fetch_done, data_done, grant, busy, state_out
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: picks fetch or load/store, sequences the fixed read latency,
// and pulses a done to the winner. Define MEM_ARB_RR_EN for round-robin tie breaking.
//
// state | meaning
// IDLE  | arbitrate when any request is present
// RWAIT | read in flight, counting down MEM_LATENCY
// WRITE | single-cycle write strobe
// DONE  | completion pulse to the granted requester
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_t      state;
    logic [3:0]  count;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [31:0] rd_data_r;
    logic        mem_wr_r;
    logic        fetch_done_r;
    logic        data_done_r;
    logic        grant_r;
    logic        pick_data;

`ifdef MEM_ARB_RR_EN
    // grant_r still holds the owner of the previous access, so it doubles as last-served
    always_comb begin
        pick_data = bus.data_req;
        if (bus.data_req && bus.fetch_req)
            pick_data = ~grant_r;
    end
`else
    always_comb begin
        pick_data = bus.data_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= 4'd0;
            mem_addr_r   <= 32'd0;
            mem_wdata_r  <= 32'd0;
            rd_data_r    <= 32'd0;
            mem_wr_r     <= 1'b0;
            fetch_done_r <= 1'b0;
            data_done_r  <= 1'b0;
            grant_r      <= 1'b0;
        end else begin
            mem_wr_r     <= 1'b0;
            fetch_done_r <= 1'b0;
            data_done_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.fetch_req || bus.data_req) begin
                        grant_r    <= pick_data;
                        mem_addr_r <= pick_data ? bus.data_addr : bus.fetch_addr;
                        if (pick_data)
                            mem_wdata_r <= bus.data_wdata;
                        if (pick_data && bus.data_wr) begin
                            mem_wr_r <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            count <= LAT;
                            state <= RWAIT;
                        end
                    end
                end
                RWAIT: begin
                    count <= count - 4'd1;
                    // <= guards against a zero count wrapping into a 15-cycle wait
                    if (count <= 4'd1) begin
                        rd_data_r    <= bus.mem_rdata;
                        fetch_done_r <= ~grant_r;
                        data_done_r  <= grant_r;
                        state        <= DONE;
                    end
                end
                WRITE: begin
                    fetch_done_r <= ~grant_r;
                    data_done_r  <= grant_r;
                    state        <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wr     = mem_wr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.rd_data    = rd_data_r;
    assign bus.fetch_done = fetch_done_r;
    assign bus.data_done  = data_done_r;
    assign bus.grant      = grant_r;
    assign bus.busy       = (state != IDLE);
    assign bus.state_out  = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: access-timeline model compared every cycle, plus directed
// scenarios with literal expectations.
module tb_mem_port_arbiter;
    localparam int L = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic        rd_force = 1'b0;
    logic [31:0] rd_val = 32'd0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MEM_LATENCY(L)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) cyc <= cyc + 1;

    assign bus.mem_rdata = rd_force ? rd_val : {16'hC0DE, cyc[15:0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: each access is a timeline indexed by k = cycles since the request was sampled.
    logic        model_ok = 1'b0;
    logic        m_active = 1'b0;
    int          m_k = 0;
    int          m_end = 0;
    logic        m_wr = 1'b0;
    logic        m_win = 1'b0;
    logic [31:0] e_addr = 32'd0;
    logic [31:0] e_wdata = 32'd0;
    logic [31:0] e_rd = 32'd0;
    logic        e_grant = 1'b0;
    logic [1:0]  e_state;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            e_addr   = 32'd0;
            e_wdata  = 32'd0;
            e_rd     = 32'd0;
            e_grant  = 1'b0;
            model_ok = 1'b1;
        end else if (!m_active) begin
            if (bus.fetch_req || bus.data_req) begin
                if (bus.fetch_req && bus.data_req)
`ifdef MEM_ARB_RR_EN
                    m_win = ~e_grant;
`else
                    m_win = 1'b1;
`endif
                else
                    m_win = bus.data_req;
                e_grant = m_win;
                e_addr  = m_win ? bus.data_addr : bus.fetch_addr;
                if (m_win) e_wdata = bus.data_wdata;
                m_wr     = m_win && bus.data_wr;
                m_end    = m_wr ? 2 : L + 1;
                m_k      = 1;
                m_active = 1'b1;
            end
        end else begin
            if (!m_wr && m_k == L) e_rd = bus.mem_rdata;
            m_k++;
            if (m_k > m_end) m_active = 1'b0;
        end
        #1;
        if (model_ok) begin
            e_state = !m_active ? 2'd0 : (m_k == m_end) ? 2'd3 : m_wr ? 2'd2 : 2'd1;
            chk("m_mem_addr",   bus.mem_addr,  e_addr);
            chk("m_mem_wdata",  bus.mem_wdata, e_wdata);
            chk("m_rd_data",    bus.rd_data,   e_rd);
            chk("m_mem_wr",     32'(bus.mem_wr),     32'(m_active && m_wr && m_k == 1));
            chk("m_fetch_done", 32'(bus.fetch_done), 32'(m_active && m_k == m_end && !e_grant));
            chk("m_data_done",  32'(bus.data_done),  32'(m_active && m_k == m_end && e_grant));
            chk("m_grant",      32'(bus.grant),      32'(e_grant));
            chk("m_busy",       32'(bus.busy),       32'(m_active));
            chk("m_state",      32'(bus.state_out),  32'(e_state));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    int done_seen;

    initial begin
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 32'd0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_addr  = 32'd0;
        bus.data_wdata = 32'd0;
        repeat (3) step();
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_busy",     32'(bus.busy), 32'h0);
        chk("rst_state",    32'(bus.state_out), 32'h0);
        chk("rst_rd_data",  bus.rd_data, 32'h0);
        reset = 1'b0;
        step();

        // fetch read, cycle 0
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h4;
        step();
        chk("rd_c1_addr",  bus.mem_addr, 32'h4);
        chk("rd_c1_state", 32'(bus.state_out), 32'h1);
        step();
        rd_force = 1'b1; rd_val = 32'h8C220000;
        chk("rd_c2_addr", bus.mem_addr, 32'h4);
        step();
        rd_force = 1'b0;
        chk("rd_c3_done", 32'(bus.fetch_done), 32'h1);
        chk("rd_c3_data", bus.rd_data, 32'h8C220000);
        chk("rd_c3_wr",   32'(bus.mem_wr), 32'h0);
        bus.fetch_req = 1'b0;
        step();
        chk("rd_c4_busy", 32'(bus.busy), 32'h0);

        // store, cycle 0
        bus.data_req = 1'b1; bus.data_wr = 1'b1;
        bus.data_addr = 32'h100; bus.data_wdata = 32'hDEADBEEF;
        step();
        chk("st_c1_wr",    32'(bus.mem_wr), 32'h1);
        chk("st_c1_addr",  bus.mem_addr, 32'h100);
        chk("st_c1_wdata", bus.mem_wdata, 32'hDEADBEEF);
        step();
        chk("st_c2_done", 32'(bus.data_done), 32'h1);
        chk("st_c2_wr",   32'(bus.mem_wr), 32'h0);
        chk("st_c2_rd",   bus.rd_data, 32'h8C220000);
        bus.data_req = 1'b0; bus.data_wr = 1'b0;
        step();

        // tie between two reads; previous owner was data
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h8;
        bus.data_req  = 1'b1; bus.data_addr  = 32'h200;
        step();
`ifdef MEM_ARB_RR_EN
        chk("rr_c1_grant", 32'(bus.grant), 32'h0);
        chk("rr_c1_addr",  bus.mem_addr, 32'h8);
        step(); step();
        chk("rr_c3_done", 32'(bus.fetch_done), 32'h1);
        bus.fetch_req = 1'b0;
        step(); step();
        chk("rr_c5_grant", 32'(bus.grant), 32'h1);
        chk("rr_c5_addr",  bus.mem_addr, 32'h200);
        step(); step();
        chk("rr_c7_done", 32'(bus.data_done), 32'h1);
        bus.data_req = 1'b0;
`else
        chk("tie_c1_grant", 32'(bus.grant), 32'h1);
        chk("tie_c1_addr",  bus.mem_addr, 32'h200);
        step(); step();
        chk("tie_c3_done", 32'(bus.data_done), 32'h1);
        bus.data_req = 1'b0;
        step();
        chk("tie_c4_state", 32'(bus.state_out), 32'h0);
        step();
        chk("tie_c5_grant", 32'(bus.grant), 32'h0);
        chk("tie_c5_addr",  bus.mem_addr, 32'h8);
        step();
        chk("tie_c6_addr", bus.mem_addr, 32'h8);
        step();
        chk("tie_c7_done", 32'(bus.fetch_done), 32'h1);
        bus.fetch_req = 1'b0;
`endif
        step();
        chk("tie_end_busy", 32'(bus.busy), 32'h0);

        // reset in cycle 1 of a fetch read
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h40;
        step();
        reset = 1'b1; bus.fetch_req = 1'b0;
        step();
        chk("rst_mid_addr",  bus.mem_addr, 32'h0);
        chk("rst_mid_state", 32'(bus.state_out), 32'h0);
        chk("rst_mid_rd",    bus.rd_data, 32'h0);
        chk("rst_mid_grant", 32'(bus.grant), 32'h0);
        chk("rst_mid_done",  32'(bus.fetch_done), 32'h0);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.fetch_done) done_seen++;
        end
        chk("rst_no_done", 32'(done_seen), 32'h0);

        // load withdrawn in cycle 1
        bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h300;
        step();
        bus.data_req = 1'b0;
        step(); step();
        chk("wd_c3_done", 32'(bus.data_done), 32'h1);
        step();
        chk("wd_c4_busy", 32'(bus.busy), 32'h0);
        step();
        chk("wd_c5_busy", 32'(bus.busy), 32'h0);

        // fetch held across two accesses: regranted in the IDLE cycle after DONE
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'hABC0;
        step(); step(); step();
        chk("hold_c3_done", 32'(bus.fetch_done), 32'h1);
        step();
        chk("hold_c4_state", 32'(bus.state_out), 32'h0);
        step(); step(); step();
        chk("hold_c7_done", 32'(bus.fetch_done), 32'h1);
        bus.fetch_req = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
